pipeline_ctrl: RTL and testbench
================================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  core clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  synchronous, active-high; sampled only on rising clk edge.
REQ-003 SHALL have ports: i_req  in  1  fetch stage has an ibus request outstanding this cycle.
REQ-004 SHALL have ports: i_data_ok  in  1  ibus returns instruction this cycle.
REQ-005 SHALL have ports: d_req  in  1  memory stage has a load/store on dbus this cycle.
REQ-006 SHALL have ports: d_data_ok  in  1  dbus completes access this cycle.
REQ-007 SHALL have ports: ex_is_load  in  1, ex_rd  in  5, id_rs1  in  5, id_rs2  in  5  load-use detection operands.
REQ-008 SHALL have ports: branch_taken  in  1  execute stage redirects PC.
REQ-009 SHALL have ports: stall_F, stall_D, stall_E, stall_M  out  1 each  hold pipeline register contents.
REQ-010 SHALL have ports: reset_D, reset_E, reset_M, reset_W  out  1 each  load zero bubble into pipeline register.
REQ-011 SHALL have ports: fetch_discard  out  1  current ibus response is wrong-path, drop it.
REQ-012 SHALL have ports: stall_cycles  out  32  count of cycles with stall_F high.

Function
REQ-013 SHALL derive dstall = d_req & ~d_data_ok; istall = (i_req & ~i_data_ok) | (istate==I_DROP).
REQ-014 SHALL derive lu = ex_is_load & (ex_rd!=0) & ((ex_rd==id_rs1)|(ex_rd==id_rs2)).
REQ-015 SHALL give priority: dstall > branch_taken > lu > istall.
REQ-016 SHALL, when dstall: stall_F=stall_D=stall_E=stall_M=1, reset_W=1, all other reset_*=0; branch_taken and lu ignored that cycle.
REQ-017 SHALL, when branch_taken and not dstall: reset_D=1, reset_E=1, stall_*=0 except stall_F=istall.
REQ-018 SHALL, when lu and not dstall/branch_taken: stall_F=1, stall_D=1, reset_E=1.
REQ-019 SHALL, when only istall: stall_F=1, reset_D=1.
REQ-020 SHALL drive reset_M=0 outside reset; all outputs combinational from inputs and registered state (zero latency).
REQ-021 SHALL keep ifetch FSM istate in {I_IDLE, I_WAIT, I_DROP}: I_IDLE->I_WAIT on i_req&~i_data_ok; I_WAIT->I_IDLE on i_data_ok; I_WAIT->I_DROP on branch_taken&~i_data_ok&~dstall; I_DROP->I_IDLE on i_data_ok.
REQ-022 SHALL assert fetch_discard only in I_DROP on the cycle i_data_ok=1; no stall_F release before that response.
REQ-023 SHALL treat branch_taken with i_req&i_data_ok in same cycle as no drop (response accepted then flushed via reset_D).
REQ-024 SHALL keep dbus FSM dstate in {D_IDLE, D_WAIT}: D_IDLE->D_WAIT on dstall; D_WAIT->D_IDLE on d_data_ok; used only for counter qualification, no effect on stalls.
REQ-025 SHALL increment stall_cycles each cycle stall_F=1, saturating at 0xFFFF_FFFF, no wrap.
REQ-026 SHALL tolerate d_data_ok with d_req=0 and i_data_ok in I_IDLE by ignoring them.

Reset
REQ-027 SHALL, while reset=1: istate=I_IDLE, dstate=D_IDLE, stall_cycles=0, all stall_*=0, all reset_*=1, fetch_discard=0.
REQ-028 SHALL abandon any outstanding ibus/dbus tracking on reset mid-transaction; first cycle after reset behaves as I_IDLE/D_IDLE.

Verification
REQ-029 SHALL cover: d_req=1, d_data_ok=0 for 3 cycles then 1 -> stall_F..M=1 and reset_W=1 for 3 cycles, all 0 on 4th; stall_cycles=3.
REQ-030 SHALL cover: ex_is_load=1, ex_rd=5, id_rs2=5 -> stall_F=stall_D=reset_E=1; ex_rd=0 same case -> no stall.
REQ-031 SHALL cover: i_req=1 no data, branch_taken pulse cycle 1, i_data_ok cycle 4 -> istate I_DROP cycles 2-4, fetch_discard=1 only cycle 4, stall_F=1 cycles 0-4.
REQ-032 SHALL cover: branch_taken and lu same cycle -> reset_D=reset_E=1, stall_D=0.
REQ-033 SHALL cover: dstall and branch_taken same cycle -> stall_E=1, reset_E=0, istate unchanged.
REQ-034 SHALL cover: reset asserted in I_DROP with stall_cycles=0xFFFF_FFFF preloaded by 2^32 stall cycles (or forced) -> counter saturates, then clears to 0, istate I_IDLE next cycle.

Source files
------------

// File: rtl/pipeline_ctrl.sv
// Pipeline hazard controller: derives per-stage stall/flush controls from
// bus handshakes, load-use hazards and taken branches, tracks in-flight
// ibus/dbus transactions, and counts fetch-stall cycles.
module pipeline_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic        i_data_ok,
    input  logic        d_req,
    input  logic        d_data_ok,
    input  logic        ex_is_load,
    input  logic [4:0]  ex_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        branch_taken,
    output logic        stall_F,
    output logic        stall_D,
    output logic        stall_E,
    output logic        stall_M,
    output logic        reset_D,
    output logic        reset_E,
    output logic        reset_M,
    output logic        reset_W,
    output logic        fetch_discard,
    output logic [31:0] stall_cycles
);

    localparam int unsigned CNT_W = 32;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        I_IDLE = 2'd0,
        I_WAIT = 2'd1,
        I_DROP = 2'd2
    } istate_t;

    typedef enum logic {
        D_IDLE = 1'b0,
        D_WAIT = 1'b1
    } dstate_t;

    istate_t          istate_q, istate_d;
    dstate_t          dstate_q, dstate_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic dstall;
    logic istall;
    logic lu;
    logic cnt_inc;

    // Hazard terms; a drop in progress keeps fetch frozen until the stale response lands
    always_comb begin
        dstall = d_req & ~d_data_ok;
        istall = (i_req & ~i_data_ok) | (istate_q == I_DROP);
        lu     = ex_is_load & (ex_rd != 5'd0) &
                 ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    end

    // Prioritised stall/flush decode: dstall > branch > load-use > istall
    always_comb begin
        stall_F       = 1'b0;
        stall_D       = 1'b0;
        stall_E       = 1'b0;
        stall_M       = 1'b0;
        reset_D       = 1'b0;
        reset_E       = 1'b0;
        reset_M       = 1'b0;
        reset_W       = 1'b0;
        fetch_discard = 1'b0;
        if (reset) begin
            reset_D = 1'b1;
            reset_E = 1'b1;
            reset_M = 1'b1;
            reset_W = 1'b1;
        end else begin
            fetch_discard = (istate_q == I_DROP) & i_data_ok;
            if (dstall) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                stall_E = 1'b1;
                stall_M = 1'b1;
                reset_W = 1'b1;
            end else if (branch_taken) begin
                stall_F = istall;
                reset_D = 1'b1;
                reset_E = 1'b1;
            end else if (lu) begin
                stall_F = 1'b1;
                stall_D = 1'b1;
                reset_E = 1'b1;
            end else if (istall) begin
                stall_F = 1'b1;
                reset_D = 1'b1;
            end
        end
    end

    // Ifetch tracker: a branch while waiting turns the pending response into a drop
    always_comb begin
        istate_d = istate_q;
        case (istate_q)
            I_IDLE: begin
                if (i_req & ~i_data_ok) begin
                    istate_d = I_WAIT;
                end
            end
            I_WAIT: begin
                if (i_data_ok) begin
                    istate_d = I_IDLE;
                end else if (branch_taken & ~dstall) begin
                    istate_d = I_DROP;
                end
            end
            I_DROP: begin
                if (i_data_ok) begin
                    istate_d = I_IDLE;
                end
            end
            default: istate_d = I_IDLE;
        endcase
    end

    // Dbus tracker: marks cycles spent waiting on a data access
    always_comb begin
        dstate_d = dstate_q;
        case (dstate_q)
            D_IDLE: begin
                if (dstall) begin
                    dstate_d = D_WAIT;
                end
            end
            D_WAIT: begin
                if (d_data_ok) begin
                    dstate_d = D_IDLE;
                end
            end
            default: dstate_d = D_IDLE;
        endcase
    end

    // Saturating fetch-stall counter; an ongoing dbus wait always counts as a fetch stall
    always_comb begin
        cnt_inc        = stall_F | ((dstate_q == D_WAIT) & dstall & ~reset);
        stall_cycles_d = stall_cycles_q;
        if (cnt_inc && (stall_cycles_q != CNT_MAX)) begin
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            istate_q       <= I_IDLE;
            dstate_q       <= D_IDLE;
            stall_cycles_q <= '0;
        end else begin
            istate_q       <= istate_d;
            dstate_q       <= dstate_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed hazard scenarios plus
// randomized traffic, compared every cycle against a transaction-level model.
module tb_pipeline_ctrl;

    logic        clk;
    logic        reset;
    logic        i_req, i_data_ok, d_req, d_data_ok, ex_is_load, branch_taken;
    logic [4:0]  ex_rd, id_rs1, id_rs2;
    logic        stall_F, stall_D, stall_E, stall_M;
    logic        reset_D, reset_E, reset_M, reset_W;
    logic        fetch_discard;
    logic [31:0] stall_cycles;

    int n_chk;
    int n_err;

    // Model state: is an ibus fetch outstanding, is its response known wrong-path
    bit          m_pending;
    bit          m_wrong_path;
    logic [31:0] m_cnt;

    pipeline_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_data_ok     (i_data_ok),
        .d_req         (d_req),
        .d_data_ok     (d_data_ok),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .branch_taken  (branch_taken),
        .stall_F       (stall_F),
        .stall_D       (stall_D),
        .stall_E       (stall_E),
        .stall_M       (stall_M),
        .reset_D       (reset_D),
        .reset_E       (reset_E),
        .reset_M       (reset_M),
        .reset_W       (reset_W),
        .fetch_discard (fetch_discard),
        .stall_cycles  (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_in(input bit r, input bit ir, input bit iok, input bit dr, input bit dok,
                          input bit ld, input int rd, input int rs1, input int rs2, input bit bt);
        reset        = r;
        i_req        = ir;
        i_data_ok    = iok;
        d_req        = dr;
        d_data_ok    = dok;
        ex_is_load   = ld;
        ex_rd        = 5'(rd);
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        branch_taken = bt;
    endtask

    // One cycle: compare outputs against the model, advance the model, move to next negedge
    task automatic step(input string tag);
        bit ds, lu, is, sF, sD, sE, sM, rD, rE, rM, rW, disc;
        ds = d_req && !d_data_ok;
        lu = ex_is_load && (ex_rd != 0) && (ex_rd == id_rs1 || ex_rd == id_rs2);
        is = (i_req && !i_data_ok) || m_wrong_path;
        {sF, sD, sE, sM, rD, rE, rM, rW} = 8'b0;
        disc = 1'b0;
        if (reset) begin
            {rD, rE, rM, rW} = 4'b1111;
        end else begin
            disc = m_wrong_path && i_data_ok;
            if (ds) begin
                {sF, sD, sE, sM} = 4'b1111;
                rW = 1'b1;
            end else if (branch_taken) begin
                sF = is;
                rD = 1'b1;
                rE = 1'b1;
            end else if (lu) begin
                sF = 1'b1;
                sD = 1'b1;
                rE = 1'b1;
            end else if (is) begin
                sF = 1'b1;
                rD = 1'b1;
            end
        end
        #2;
        check({tag, "_ctl"},
              32'({stall_F, stall_D, stall_E, stall_M, reset_D, reset_E, reset_M, reset_W, fetch_discard}),
              32'({sF, sD, sE, sM, rD, rE, rM, rW, disc}));
        check({tag, "_cnt"}, stall_cycles, m_cnt);
        if (reset) begin
            m_pending    = 1'b0;
            m_wrong_path = 1'b0;
            m_cnt        = '0;
        end else begin
            if (sF && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
            if (m_wrong_path || m_pending) begin
                if (i_data_ok) begin
                    m_pending    = 1'b0;
                    m_wrong_path = 1'b0;
                end else if (m_pending && branch_taken && !ds) begin
                    m_pending    = 1'b0;
                    m_wrong_path = 1'b1;
                end
            end else if (i_req && !i_data_ok) begin
                m_pending = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst");
    endtask

    initial begin
        n_chk        = 0;
        n_err        = 0;
        m_pending    = 1'b0;
        m_wrong_path = 1'b0;
        m_cnt        = '0;
        set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        step("rst0");
        step("rst1");

        // dbus wait of three cycles then completion
        set_in(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        repeat (3) step("dwait");
        set_in(0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        step("ddone");
        check("dwait_cnt3", stall_cycles, 32'd3);

        // load-use on rs2, then same with rd=x0 (no hazard)
        do_reset();
        set_in(0, 0, 0, 0, 0, 1, 5, 1, 5, 0);
        step("lu_rs2");
        set_in(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        step("lu_x0");
        check("lu_x0_cnt", stall_cycles, 32'd1);

        // fetch miss, branch in cycle 1, stale response in cycle 4
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drop_c0");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("drop_c1");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drop_c2");
        step("drop_c3");
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("drop_c4");
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("drop_c5");
        check("drop_cnt5", stall_cycles, 32'd5);

        // branch with a load-use hazard in the same cycle
        set_in(0, 0, 0, 0, 0, 1, 7, 7, 2, 1);
        step("br_lu");
        // dstall with branch while fetch is pending: branch ignored, no drop afterward
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("ds_br_a");
        set_in(0, 1, 0, 1, 0, 0, 0, 0, 0, 1);
        step("ds_br_b");
        set_in(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        step("ds_br_c");
        // stray acknowledgements with nothing outstanding
        set_in(0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
        step("stray");

        // saturation, then reset while dropping
        do_reset();
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("sat_c0");
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        step("sat_c1");
        force dut.stall_cycles_q = 32'hFFFF_FFFD;
        #1;
        release dut.stall_cycles_q;
        m_cnt = 32'hFFFF_FFFD;
        set_in(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (5) step("sat_drop");
        check("sat_hold", stall_cycles, 32'hFFFF_FFFF);
        set_in(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        step("rst_in_drop");
        check("rst_clr", stall_cycles, 32'd0);
        set_in(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step("post_rst_idle");

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            set_in($urandom_range(99) < 2,
                   $urandom_range(99) < 60,
                   $urandom_range(99) < 35,
                   $urandom_range(99) < 30,
                   $urandom_range(99) < 50,
                   $urandom_range(99) < 40,
                   int'($urandom_range(3)),
                   int'($urandom_range(3)),
                   int'($urandom_range(3)),
                   $urandom_range(99) < 15);
            step("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
